histeq_axil_regbank: RTL and testbench
======================================

# histeq_axil_regbank

Parametrised AXI4-Lite slave register bank for the histogram-equalization IP: the next generation of the fixed four-register control interface, generalised to N registers with byte strobes, read-only status registers, write-1-to-clear sticky bits, per-register write pulses and a level interrupt. It sits between the AXI4-Lite interconnect and the histogram datapath, supplying configuration and collecting status/event flags.

## Interface
- C_DATA_WIDTH, 32, register and AXI data width; 32 or 64 only.
- NUM_REGS, 16, number of registers; 2..64.
- C_ADDR_WIDTH, 6, AXI address width; must be >= clog2(NUM_REGS)+clog2(C_DATA_WIDTH/8).
- RO_MASK, 0, NUM_REGS-bit; bit i=1 makes reg i read-only, value taken from hw_in.
- W1C_MASK, 0, NUM_REGS-bit; bit i=1 makes reg i sticky write-1-to-clear, bits set by hw_set. RO takes precedence over W1C.
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR / AWVALID / AWREADY  in/in/out  C_ADDR_WIDTH/1/1  write address channel; AWPROT accepted and ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  C_DATA_WIDTH/C_DATA_WIDTH/8/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR / ARVALID / ARREADY  in/in/out  C_ADDR_WIDTH/1/1  read address; ARPROT ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  C_DATA_WIDTH/2/1/1  read data.
- reg_out  out  NUM_REGS*C_DATA_WIDTH  current value of every register (reg i at slice i).
- hw_in  in  NUM_REGS*C_DATA_WIDTH  values for RO registers; unused slices ignored.
- hw_set  in  NUM_REGS*C_DATA_WIDTH  per-bit set pulses for W1C registers; unused slices ignored.
- wr_pulse  out  NUM_REGS  one-cycle strobe when reg i is written by software.
- irq  out  1  OR of all bits of all W1C registers, registered.

## Operation
- Register index = addr[C_ADDR_WIDTH-1 : clog2(C_DATA_WIDTH/8)]; low byte-offset bits ignored. Index >= NUM_REGS is out of range.
- Write: AWREADY and WREADY assert together for exactly one cycle when AWVALID & WVALID & !BVALID; one outstanding write. Address and data must both be present; neither channel is accepted alone.
- RW register: bytes with WSTRB=1 updated, others held.
- W1C register: for each strobed byte, bits written 1 are cleared. hw_set bit=1 sets the bit; simultaneous hw_set and software clear on the same bit: set wins.
- RO register: write ignored, BRESP=OKAY, wr_pulse still asserted.
- Out-of-range write: no state change, no wr_pulse, BRESP=SLVERR (2'b10).
- Read: ARREADY asserts one cycle when ARVALID & !RVALID; RDATA = reg_out slice (RO: hw_in sampled at handshake). Out-of-range: RDATA=0, RRESP=SLVERR.
- BVALID/RVALID held until BREADY/RREADY; RDATA/BRESP stable while valid.
- Reads and writes proceed independently; same-cycle read and write of one register returns the pre-write value.

## Timing
- Reset (ARESETN low, asynchronous): all registers 0, all READY/VALID 0, BRESP/RRESP 0, RDATA 0, wr_pulse 0, irq 0. Reset mid-transaction abandons it; no response issued after release.
- Write handshake on edge N: register updated, wr_pulse high, BVALID high, all visible after edge N (cycle N+1). wr_pulse drops after one cycle.
- Next write accepted no earlier than the cycle after B handshake; back-to-back with BREADY=1 throughput is one write per 2 cycles.
- Read handshake on edge N: RVALID/RDATA valid in cycle N+1; throughput one read per 2 cycles with RREADY=1.
- hw_set on edge N visible in reg_out at N+1, irq at N+2.

## Test plan
- Defaults (NUM_REGS=16, W1C_MASK=16'h0008, RO_MASK=16'h0004): write 1,2,3,4 to addrs 0x0,0x4,0x10,0x14, read back -> 1,2,3,4, OKAY, wr_pulse bits 0,1,4,5 each pulse once.
- Write 0xAABBCCDD to 0x0 then 0x11223344 with WSTRB=4'b0101 -> read 0xAA22CC44.
- Pulse hw_set slice 3 = 0x0000_0081 -> irq high 2 cycles later; write 0x01 to 0xC -> reads 0x80, irq still 1; write 0x80 -> irq 0; same-cycle set/clear of bit 0 -> bit stays 1.
- hw_in slice 2 = 0xDEADBEEF; write 0 to 0x8 -> OKAY, read 0x8 -> 0xDEADBEEF.
- Write/read addr 0x40 -> BRESP/RRESP SLVERR, RDATA 0, no register changed.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and payload stable, no new AW/W/AR accepted; drop ARESETN mid-wait -> all outputs 0 immediately, registers 0.

Source files
------------

// File: rtl/histeq_axil_regbank.sv
// AXI4-Lite register bank for the histogram-equalization IP.
// RW, read-only and sticky W1C registers with per-register write strobes.
module histeq_axil_regbank #(
  parameter int C_DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int C_ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic S_AXI_AWVALID,
  output logic S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic S_AXI_WVALID,
  output logic S_AXI_WREADY,
  output logic [1:0] S_AXI_BRESP,
  output logic S_AXI_BVALID,
  input  logic S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic S_AXI_ARVALID,
  output logic S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0] S_AXI_RRESP,
  output logic S_AXI_RVALID,
  input  logic S_AXI_RREADY,
  output logic [NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*C_DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0] wr_pulse,
  output logic irq
);

  localparam int DW = C_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int SB = $clog2(NB);
  localparam int IW = C_ADDR_WIDTH - SB;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d, reg_val;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic irq_q, irq_d;
  logic awready_q, arready_q;
  logic bvalid_q, rvalid_q;
  logic [1:0] bresp_q, rresp_q;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [IW-1:0] widx, ridx;
  logic w_oor, r_oor, wr_hs, rd_hs;
  logic unused_ok;

  assign widx = S_AXI_AWADDR[C_ADDR_WIDTH-1:SB];
  assign ridx = S_AXI_ARADDR[C_ADDR_WIDTH-1:SB];
  assign w_oor = 32'(widx) >= 32'(NUM_REGS);
  assign r_oor = 32'(ridx) >= 32'(NUM_REGS);
  assign wr_hs = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs = arready_q & S_AXI_ARVALID;
  assign unused_ok = ^{hw_in, hw_set,
                       S_AXI_AWADDR[SB-1:0], S_AXI_ARADDR[SB-1:0]};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_val[i] = RO_MASK[i] ? hw_in[i*DW +: DW] : regs_q[i];
    end
  end

  assign reg_out = reg_val;

  // RO wins over W1C; hw_set is OR-ed after the clear so set wins
  always_comb begin
    regs_d = regs_q;
    wr_pulse_d = '0;
    irq_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hs && widx == IW'(i)) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (S_AXI_WSTRB[b]) begin
            if (W1C_MASK[i])
              regs_d[i][8*b +: 8] = regs_q[i][8*b +: 8]
                                    & ~S_AXI_WDATA[8*b +: 8];
            else
              regs_d[i][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
          end
        end
      end
      if (W1C_MASK[i])
        regs_d[i] = regs_d[i] | hw_set[i*DW +: DW];
      if (RO_MASK[i])
        regs_d[i] = '0;
      if (W1C_MASK[i] && !RO_MASK[i])
        irq_d = irq_d | (|regs_q[i]);
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == IW'(i))
        rdata_d = reg_val[i];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      regs_q <= '0;
      wr_pulse_q <= '0;
      irq_q <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q <= OKAY;
      rresp_q <= OKAY;
      rdata_q <= '0;
    end else begin
      regs_q <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      irq_q <= irq_d;
      // ready looks ahead at the response slot so a held request
      // is taken the cycle after the previous response retires
      awready_q <= !awready_q & S_AXI_AWVALID & S_AXI_WVALID
                   & (!bvalid_q | S_AXI_BREADY);
      arready_q <= !arready_q & S_AXI_ARVALID
                   & (!rvalid_q | S_AXI_RREADY);
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q <= w_oor ? SLVERR : OKAY;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q <= rdata_d;
        rresp_q <= r_oor ? SLVERR : OKAY;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY = awready_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign wr_pulse = wr_pulse_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_histeq_axil_regbank.sv
// Directed bench for histeq_axil_regbank.
// Reg 2 read-only, reg 3 sticky W1C, 7-bit address for an out-of-range slot.
module tb_histeq_axil_regbank;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] awaddr, araddr;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [511:0] reg_out, hw_in, hw_set;
  logic [15:0] wr_pulse;
  logic irq;

  int n_vec = 0;
  int n_err = 0;
  int pcnt [16];

  always #5 clk = ~clk;

  histeq_axil_regbank #(
    .C_DATA_WIDTH(32), .NUM_REGS(16), .C_ADDR_WIDTH(7),
    .RO_MASK(16'h0004), .W1C_MASK(16'h0008)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .hw_in(hw_in), .hw_set(hw_set),
    .wr_pulse(wr_pulse), .irq(irq)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++)
      if (wr_pulse[i]) pcnt[i]++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [6:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] hs3,
                        output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) chk("aw_tmo", {63'd0, awready}, 64'd1);
    hw_set[127:96] = hs3;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; hw_set[127:96] = '0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) chk("b_tmo", {63'd0, bvalid}, 64'd1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [6:0] a,
                        output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) chk("ar_tmo", {63'd0, arready}, 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) chk("r_tmo", {63'd0, rvalid}, 64'd1);
    d = rdata; resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  logic [1:0] rsp;
  logic [31:0] rd;
  int psum0, psum1, n;

  initial begin
    logic [6:0] a4 [4];
    a4 = '{7'h00, 7'h04, 7'h10, 7'h14};
    for (int i = 0; i < 16; i++) pcnt[i] = 0;
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    hw_in = '0; hw_set = '0;
    repeat (3) @(negedge clk);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_regs", reg_out[63:0], 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      axi_wr(a4[i], 32'(i + 1), 4'hF, 32'h0, rsp);
      chk("wr_resp", {62'd0, rsp}, 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_rd(a4[i], rd, rsp);
      chk("rd_data", {32'd0, rd}, 64'(i + 1));
      chk("rd_resp", {62'd0, rsp}, 64'd0);
    end
    chk("pulse0", 64'(pcnt[0]), 64'd1);
    chk("pulse1", 64'(pcnt[1]), 64'd1);
    chk("pulse4", 64'(pcnt[4]), 64'd1);
    chk("pulse5", 64'(pcnt[5]), 64'd1);
    chk("pulse2", 64'(pcnt[2]), 64'd0);

    axi_wr(7'h00, 32'hAABBCCDD, 4'hF, 32'h0, rsp);
    axi_wr(7'h00, 32'h11223344, 4'b0101, 32'h0, rsp);
    axi_rd(7'h00, rd, rsp);
    chk("strb_data", {32'd0, rd}, 64'hAA22CC44);

    @(negedge clk); hw_set[127:96] = 32'h81;
    @(negedge clk); hw_set[127:96] = '0;
    chk("set_reg", {32'd0, reg_out[127:96]}, 64'h81);
    chk("set_irq_n1", {63'd0, irq}, 64'd0);
    @(negedge clk);
    chk("set_irq_n2", {63'd0, irq}, 64'd1);
    axi_wr(7'h0C, 32'h01, 4'hF, 32'h0, rsp);
    axi_rd(7'h0C, rd, rsp);
    chk("w1c_part", {32'd0, rd}, 64'h80);
    chk("w1c_irq1", {63'd0, irq}, 64'd1);
    axi_wr(7'h0C, 32'h80, 4'hF, 32'h0, rsp);
    repeat (2) @(negedge clk);
    chk("w1c_irq0", {63'd0, irq}, 64'd0);
    axi_rd(7'h0C, rd, rsp);
    chk("w1c_zero", {32'd0, rd}, 64'h0);
    axi_wr(7'h0C, 32'h01, 4'hF, 32'h01, rsp);
    axi_rd(7'h0C, rd, rsp);
    chk("set_wins", {32'd0, rd}, 64'h1);

    hw_in[95:64] = 32'hDEADBEEF;
    axi_wr(7'h08, 32'h0, 4'hF, 32'h0, rsp);
    chk("ro_resp", {62'd0, rsp}, 64'd0);
    chk("ro_pulse", 64'(pcnt[2]), 64'd1);
    axi_rd(7'h08, rd, rsp);
    chk("ro_data", {32'd0, rd}, 64'hDEADBEEF);

    psum0 = 0;
    for (int i = 0; i < 16; i++) psum0 += pcnt[i];
    axi_wr(7'h40, 32'hFFFFFFFF, 4'hF, 32'h0, rsp);
    chk("oor_bresp", {62'd0, rsp}, 64'd2);
    axi_rd(7'h40, rd, rsp);
    chk("oor_rdata", {32'd0, rd}, 64'd0);
    chk("oor_rresp", {62'd0, rsp}, 64'd2);
    psum1 = 0;
    for (int i = 0; i < 16; i++) psum1 += pcnt[i];
    chk("oor_pulse", 64'(psum1), 64'(psum0));
    chk("oor_reg0", {32'd0, reg_out[31:0]}, 64'hAA22CC44);
    chk("oor_reg1", {32'd0, reg_out[63:32]}, 64'h2);

    @(negedge clk);
    awaddr = 7'h14; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) chk("st_aw_tmo", {63'd0, awready}, 64'd1);
    @(negedge clk);
    awaddr = 7'h00; wdata = 32'h99;
    araddr = 7'h10; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) chk("st_ar_tmo", {63'd0, arready}, 64'd1);
    @(negedge clk);
    araddr = 7'h00;
    for (int k = 0; k < 5; k++) begin
      chk("st_bvalid", {63'd0, bvalid}, 64'd1);
      chk("st_bresp", {62'd0, bresp}, 64'd0);
      chk("st_awready", {63'd0, awready}, 64'd0);
      chk("st_rvalid", {63'd0, rvalid}, 64'd1);
      chk("st_rdata", {32'd0, rdata}, 64'h3);
      chk("st_arready", {63'd0, arready}, 64'd0);
      @(negedge clk);
    end
    chk("st_reg5", {32'd0, reg_out[191:160]}, 64'h55);
    chk("st_reg0", {32'd0, reg_out[31:0]}, 64'hAA22CC44);
    chk("st_irq", {63'd0, irq}, 64'd1);

    #2 rst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    #1;
    chk("ar_bvalid", {63'd0, bvalid}, 64'd0);
    chk("ar_rvalid", {63'd0, rvalid}, 64'd0);
    chk("ar_rdata", {32'd0, rdata}, 64'd0);
    chk("ar_irq", {63'd0, irq}, 64'd0);
    chk("ar_pulse", {48'd0, wr_pulse}, 64'd0);
    chk("ar_reg0", {32'd0, reg_out[31:0]}, 64'd0);
    chk("ar_reg3", {32'd0, reg_out[127:96]}, 64'd0);
    chk("ar_reg5", {32'd0, reg_out[191:160]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_bvalid", {63'd0, bvalid}, 64'd0);
    chk("post_rvalid", {63'd0, rvalid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
